// File: rtl/data_mem_arbiter.sv
// Data-memory port arbiter between the pipeline MEM stage and a host loader.
// The CPU normally wins; a starved host forces a bounded burst of grants.
module data_mem_arbiter #(
  parameter int unsigned WAIT_MAX  = 8,
  parameter int unsigned BURST_MAX = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  output logic [31:0] cpu_rdata_o,
  output logic        stall_cpu_o,
  input  logic        host_req_i,
  input  logic        host_we_i,
  input  logic [31:0] host_addr_i,
  input  logic [31:0] host_wdata_i,
  output logic        host_gnt_o,
  output logic        host_rvalid_o,
  output logic [31:0] host_rdata_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned WaitWRaw = $clog2(WAIT_MAX + 1);
  localparam int unsigned WaitW    = (WaitWRaw > 4) ? WaitWRaw : 4;
  localparam int unsigned BurstW   = (BURST_MAX > 1) ? $clog2(BURST_MAX + 1) : 1;

  typedef enum logic [1:0] {StIdle, StCpu, StHostFree, StHostForced} state_e;

  state_e              state_q, state_d;
  logic [WaitW-1:0]    wait_cnt_q, wait_cnt_d;
  logic [BurstW-1:0]   burst_cnt_q, burst_cnt_d;
  logic                host_rvalid_q, host_rvalid_d;
  logic [31:0]         host_rdata_q, host_rdata_d;

  logic force_active;
  logic grant_host;
  logic grant_cpu;

  always_comb begin
    force_active = ((state_q == StHostForced) && (burst_cnt_q < BurstW'(BURST_MAX))) ||
                   (wait_cnt_q == WaitW'(WAIT_MAX));
    // Grants are suppressed combinationally while reset is held.
    grant_host   = rst_ni & host_req_i & (~cpu_req_i | force_active);
    grant_cpu    = rst_ni & cpu_req_i & ~grant_host;

    if (grant_host && cpu_req_i)   state_d = StHostForced;
    else if (grant_host)           state_d = StHostFree;
    else if (grant_cpu)            state_d = StCpu;
    else                           state_d = StIdle;

    if (grant_host || !host_req_i)                 wait_cnt_d = '0;
    else if (wait_cnt_q != WaitW'(WAIT_MAX))       wait_cnt_d = wait_cnt_q + WaitW'(1);
    else                                           wait_cnt_d = wait_cnt_q;

    if (state_d != StHostForced)                   burst_cnt_d = '0;
    else if (burst_cnt_q != BurstW'(BURST_MAX))    burst_cnt_d = burst_cnt_q + BurstW'(1);
    else                                           burst_cnt_d = burst_cnt_q;

    host_rvalid_d = grant_host & ~host_we_i;
    host_rdata_d  = host_rvalid_d ? mem_rdata_i : host_rdata_q;

    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (grant_host) begin
      mem_we_o    = host_we_i;
      mem_addr_o  = host_addr_i;
      mem_wdata_o = host_wdata_i;
    end else if (grant_cpu) begin
      mem_we_o    = cpu_we_i;
      mem_addr_o  = cpu_addr_i;
      mem_wdata_o = cpu_wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      wait_cnt_q    <= '0;
      burst_cnt_q   <= '0;
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      burst_cnt_q   <= burst_cnt_d;
      host_rvalid_q <= host_rvalid_d;
      host_rdata_q  <= host_rdata_d;
    end
  end

  assign cpu_rdata_o   = mem_rdata_i;
  assign stall_cpu_o   = cpu_req_i & grant_host;
  assign host_gnt_o    = grant_host;
  assign host_rvalid_o = host_rvalid_q;
  assign host_rdata_o  = host_rdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a small combinational-read memory model.
module tb_data_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        stall;
  logic        host_req, host_we;
  logic [31:0] host_addr, host_wdata;
  logic        host_gnt, host_rvalid;
  logic [31:0] host_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [0:63];

  int vec  = 0;
  int errs = 0;

  data_mem_arbiter #(.WAIT_MAX(8), .BURST_MAX(4)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .cpu_req_i    (cpu_req),
    .cpu_we_i     (cpu_we),
    .cpu_addr_i   (cpu_addr),
    .cpu_wdata_i  (cpu_wdata),
    .cpu_rdata_o  (cpu_rdata),
    .stall_cpu_o  (stall),
    .host_req_i   (host_req),
    .host_we_i    (host_we),
    .host_addr_i  (host_addr),
    .host_wdata_i (host_wdata),
    .host_gnt_o   (host_gnt),
    .host_rvalid_o(host_rvalid),
    .host_rdata_o (host_rdata),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_i  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;

  task automatic idle_cycle();
    @(negedge clk);
    cpu_req  = 1'b0;
    host_req = 1'b0;
    cpu_we   = 1'b0;
    host_we  = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; cpu_req = 1'b1; host_req = 1'b1; cpu_we = 1'b1; host_we = 1'b0;
    cpu_addr = 32'h4; cpu_wdata = 32'h11; host_addr = 32'h8;
    #1;
    vec++;
    if ({mem_we, stall, host_gnt, host_rvalid} !== 4'b0000) begin
      errs++;
      $display("FAIL reset_ctrl: got we/stall/gnt/rvalid=%b want 0000",
               {mem_we, stall, host_gnt, host_rvalid});
    end
    vec++;
    if ({mem_addr, mem_wdata} !== 64'h0) begin
      errs++;
      $display("FAIL reset_bus: got addr=%h wdata=%h want 0/0", mem_addr, mem_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vec++;
    if ({host_gnt, stall, mem_we, mem_addr} !== {3'b001, 32'h4}) begin
      errs++;
      $display("FAIL reset_release_cpu_first: got gnt=%b stall=%b we=%b addr=%h want 0 0 1 00000004",
               host_gnt, stall, mem_we, mem_addr);
    end
    idle_cycle();
  endtask

  task automatic test_cpu_write();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF; host_req = 1'b0;
    #1;
    vec++;
    if ({mem_we, stall, host_gnt, mem_addr, mem_wdata} !== {3'b100, 32'h10, 32'hDEADBEEF}) begin
      errs++;
      $display("FAIL cpu_write: got we=%b stall=%b gnt=%b addr=%h wdata=%h want 1 0 0 10 deadbeef",
               mem_we, stall, host_gnt, mem_addr, mem_wdata);
    end
    @(negedge clk);
    cpu_we = 1'b0;
    #1;
    vec++;
    if (cpu_rdata !== 32'hDEADBEEF) begin
      errs++;
      $display("FAIL cpu_read_back: got %h want deadbeef", cpu_rdata);
    end
    // Seed the word the host reads next.
    @(negedge clk);
    cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'h00001234;
    idle_cycle();
  endtask

  task automatic test_host_read();
    @(negedge clk);
    host_req = 1'b1; host_we = 1'b0; host_addr = 32'h20;
    #1;
    vec++;
    if ({host_gnt, stall, mem_we, mem_addr} !== {3'b100, 32'h20}) begin
      errs++;
      $display("FAIL host_read_grant: got gnt=%b stall=%b we=%b addr=%h want 1 0 0 20",
               host_gnt, stall, mem_we, mem_addr);
    end
    idle_cycle();
    #1;
    vec++;
    if ({host_rvalid, host_rdata} !== {1'b1, 32'h00001234}) begin
      errs++;
      $display("FAIL host_rvalid: got rvalid=%b rdata=%h want 1 00001234", host_rvalid, host_rdata);
    end
    vec++;
    if ({mem_we, mem_addr, mem_wdata} !== 65'h0) begin
      errs++;
      $display("FAIL idle_bus: got we=%b addr=%h wdata=%h want 0 0 0", mem_we, mem_addr, mem_wdata);
    end
    idle_cycle();
    #1;
    vec++;
    if ({host_rvalid, host_rdata} !== {1'b0, 32'h00001234}) begin
      errs++;
      $display("FAIL host_rdata_hold: got rvalid=%b rdata=%h want 0 00001234", host_rvalid, host_rdata);
    end
  endtask

  task automatic test_host_write();
    @(negedge clk);
    host_req = 1'b1; host_we = 1'b1; host_addr = 32'h24; host_wdata = 32'h0000CAFE;
    #1;
    vec++;
    if ({host_gnt, mem_we, mem_addr, mem_wdata} !== {2'b11, 32'h24, 32'h0000CAFE}) begin
      errs++;
      $display("FAIL host_write: got gnt=%b we=%b addr=%h wdata=%h want 1 1 24 0000cafe",
               host_gnt, mem_we, mem_addr, mem_wdata);
    end
    idle_cycle();
    cpu_req = 1'b1; cpu_addr = 32'h24;
    #1;
    vec++;
    if ({host_rvalid, cpu_rdata} !== {1'b0, 32'h0000CAFE}) begin
      errs++;
      $display("FAIL host_write_no_rvalid: got rvalid=%b data=%h want 0 0000cafe",
               host_rvalid, cpu_rdata);
    end
    idle_cycle();
  endtask

  task automatic test_pattern();
    logic        exp_h;
    logic [33:0] exp;
    cpu_addr = 32'h40; host_addr = 32'h80;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      cpu_req = 1'b1; host_req = 1'b1;
      #1;
      exp_h = ((i % 12) >= 8);
      exp   = {exp_h, exp_h, exp_h ? 32'h80 : 32'h40};
      vec++;
      if ({host_gnt, stall, mem_addr} !== exp) begin
        errs++;
        $display("FAIL pattern cyc%0d: got gnt=%b stall=%b addr=%h want gnt=%b stall=%b addr=%h",
                 i, host_gnt, stall, mem_addr, exp[33], exp[32], exp[31:0]);
      end
    end
    idle_cycle();
  endtask

  task automatic test_host_drop();
    logic        exp_h;
    logic [33:0] exp;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      cpu_req = 1'b1; host_req = (i != 10);
      #1;
      exp_h = (i == 8) || (i == 9) || (i >= 19 && i <= 22);
      exp   = {exp_h, exp_h, exp_h ? 32'h80 : 32'h40};
      vec++;
      if ({host_gnt, stall, mem_addr} !== exp) begin
        errs++;
        $display("FAIL host_drop cyc%0d: got gnt=%b stall=%b addr=%h want gnt=%b stall=%b addr=%h",
                 i, host_gnt, stall, mem_addr, exp[33], exp[32], exp[31:0]);
      end
    end
    idle_cycle();
  endtask

  task automatic test_reset_mid_burst();
    logic        exp_h;
    logic [33:0] exp;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      cpu_req = 1'b1; host_req = 1'b1;
      #1;
      exp_h = (i >= 8);
      exp   = {exp_h, exp_h, exp_h ? 32'h80 : 32'h40};
      vec++;
      if ({host_gnt, stall, mem_addr} !== exp) begin
        errs++;
        $display("FAIL pre_reset cyc%0d: got gnt=%b stall=%b addr=%h want gnt=%b stall=%b addr=%h",
                 i, host_gnt, stall, mem_addr, exp[33], exp[32], exp[31:0]);
      end
    end
    #1;
    rst_n = 1'b0;
    #1;
    vec++;
    if ({host_gnt, stall, mem_we, host_rvalid, mem_addr} !== 36'h0) begin
      errs++;
      $display("FAIL mid_burst_reset: got gnt=%b stall=%b we=%b rvalid=%b addr=%h want all 0",
               host_gnt, stall, mem_we, host_rvalid, mem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 13; j++) begin
      if (j > 0) @(negedge clk);
      #1;
      exp_h = ((j % 12) >= 8);
      exp   = {exp_h, exp_h, exp_h ? 32'h80 : 32'h40};
      vec++;
      if ({host_gnt, stall, mem_addr} !== exp) begin
        errs++;
        $display("FAIL post_reset cyc%0d: got gnt=%b stall=%b addr=%h want gnt=%b stall=%b addr=%h",
                 j, host_gnt, stall, mem_addr, exp[33], exp[32], exp[31:0]);
      end
    end
    idle_cycle();
  endtask

  initial begin
    rst_n = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    test_reset();
    test_cpu_write();
    test_host_read();
    test_host_write();
    test_pattern();
    test_host_drop();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter WAIT_MAX, default 8: cycles a host request may wait behind CPU traffic before it forces ownership.
REQ-002 Parameter BURST_MAX, default 4: maximum consecutive forced host grants.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 cpu_req  in  1  MEM-stage access valid (load or store).
REQ-006 cpu_we  in  1  MEM-stage store.
REQ-007 cpu_addr  in  32  MEM-stage address (ALUOutM).
REQ-008 cpu_wdata  in  32  store data (WriteDataM).
REQ-009 cpu_rdata  out  32  load data to the pipeline.
REQ-010 StallCPU  out  1  freezes the pipeline while the CPU is denied.
REQ-011 host_req, host_we  in  1 each  host loader request and write.
REQ-012 host_addr, host_wdata  in  32 each  host address and write data.
REQ-013 host_gnt  out  1  host access performed this cycle.
REQ-014 host_rvalid  out  1  host read data valid (registered).
REQ-015 host_rdata  out  32  host read data (registered).
REQ-016 mem_we  out  1;  mem_addr, mem_wdata  out  32 each;  mem_rdata  in  32. Memory reads combinationally and writes synchronously.

Function
REQ-017 The block arbitrates the single data-memory port between the pipeline MEM stage and the host, with one access per cycle.
REQ-018 The block has states IDLE, CPU, HOST_FREE and HOST_FORCED, and the state records the previous cycle's grant type.
REQ-019 force_active is high in HOST_FORCED while burst_cnt < BURST_MAX.
  - It is also high in the cycle where wait_cnt == WAIT_MAX.
REQ-020 Grant rules:
  - grant_host = host_req & (!cpu_req | force_active).
  - grant_cpu = cpu_req & !grant_host.
  - Both grants are combinational, same cycle.
REQ-021 StallCPU = cpu_req & grant_host; host_gnt = grant_host.
REQ-022 Memory port mux:
  - mem_we/addr/wdata come from the granted requester.
  - With no grant: mem_we=0, mem_addr=0, mem_wdata=0.
REQ-023 cpu_rdata = mem_rdata, combinational pass-through.
REQ-024 wait_cnt (4 bits minimum):
  - Increments, saturating at WAIT_MAX, each cycle host_req & !grant_host.
  - Clears on grant_host or !host_req.
REQ-025 burst_cnt:
  - Increments on each forced grant (grant_host & cpu_req).
  - Clears whenever the state leaves HOST_FORCED.
REQ-026 Transitions:
  - Forced grant -> HOST_FORCED.
  - Host grant with cpu_req low -> HOST_FREE.
  - grant_cpu -> CPU.
  - No grant -> IDLE.
  - HOST_FORCED exits once burst_cnt reaches BURST_MAX or host_req drops.
REQ-027 After a forced burst ends, wait_cnt restarts from 0, so the CPU is guaranteed at least WAIT_MAX grants before the next forced burst.
REQ-028 On a granted host read, host_rdata <= mem_rdata and host_rvalid pulses 1 the next cycle; otherwise host_rvalid=0 and host_rdata holds.
REQ-029 Host writes never assert host_rvalid.
REQ-030 Simultaneous requests with wait_cnt < WAIT_MAX and not in a forced burst: the CPU wins and host wait_cnt increments.

Reset
REQ-031 reset low asynchronously clears:
  - state to IDLE;
  - wait_cnt and burst_cnt to 0;
  - host_rvalid to 0 and host_rdata to 0.
REQ-032 While reset is low, grant_cpu, grant_host, StallCPU and mem_we are forced to 0; mem_addr and mem_wdata are forced to 0.
REQ-033 Reset asserted mid-burst aborts the burst; the first cycle after release follows the REQ-020 rules from IDLE.

Verification
REQ-034 Reset low with cpu_req=host_req=1 -> mem_we=0, StallCPU=0, host_gnt=0, host_rvalid=0; after release, the CPU is granted first.
REQ-035 cpu_req=1, cpu_we=1, addr 0x10, data 0xDEADBEEF, host idle -> same-cycle mem_we=1, mem_addr=0x10, StallCPU=0.
REQ-036 host_req=1 read 0x20, memory holds 0x00001234, CPU idle -> host_gnt=1 same cycle; next cycle host_rvalid=1, host_rdata=0x00001234.
REQ-037 cpu_req and host_req held high continuously (defaults) -> repeating 12-cycle pattern:
  - cycles 0-7: CPU granted;
  - cycles 8-11: host granted with StallCPU=1.
REQ-038 Host drops host_req after 2 forced grants -> CPU granted the next cycle, StallCPU=0, burst_cnt=0.
REQ-039 Reset pulsed during the 3rd forced grant -> outputs drop immediately; after release, wait_cnt counts from 0 and the CPU is granted.
